// File: rtl/usb_fs_receiver.sv
// USB full-speed receive front end: 2-flop sync, bit recovery, NRZI/unstuff, single-packet capture.
// read_data lags read_address by one cycle; packets arriving while one is held are decoded but dropped.
module usb_fs_receiver #(
  parameter int OVERSAMPLE          = 4,
  parameter int BUFFER_BYTES        = 64,
  parameter int RESET_DETECT_CYCLES = 120,
  parameter int ADDR_WIDTH          = $clog2(BUFFER_BYTES),
  parameter int LENGTH_WIDTH        = $clog2(BUFFER_BYTES + 1)
) (
  input  logic                    clock48,
  input  logic                    reset,
  input  logic                    data,
  input  logic                    data_n,
  output logic                    bus_reset,
  output logic                    packet_ready,
  output logic [LENGTH_WIDTH-1:0] packet_length,
  output logic                    packet_error,
  output logic                    packet_dropped,
  input  logic                    packet_ack,
  input  logic [ADDR_WIDTH-1:0]   read_address,
  output logic [7:0]              read_data
);
  localparam int PHASE_W = $clog2(OVERSAMPLE);
  localparam int RST_W   = $clog2(RESET_DETECT_CYCLES + 1);
  localparam logic [PHASE_W-1:0]      PHASE_SAMPLE = PHASE_W'(OVERSAMPLE / 2);
  localparam logic [PHASE_W-1:0]      PHASE_LAST   = PHASE_W'(OVERSAMPLE - 1);
  localparam logic [RST_W-1:0]        RST_LIMIT    = RST_W'(RESET_DETECT_CYCLES);
  localparam logic [LENGTH_WIDTH-1:0] BUF_FULL     = LENGTH_WIDTH'(BUFFER_BYTES);

  typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP, WAIT_IDLE} state_t;

  logic                    dp_meta_q, dp_sync_q, dp_prev_q, dn_meta_q, dn_sync_q;
  logic [PHASE_W-1:0]      phase_q, phase_d, phase_now;
  logic [RST_W-1:0]        se0_cnt_q, se0_cnt_d;
  state_t                  state_q, state_d;
  logic                    prev_lvl_q, prev_lvl_d;
  logic [6:0]              shift_q, shift_d;
  logic [2:0]              bit_cnt_q, bit_cnt_d;
  logic [2:0]              ones_q, ones_d;
  logic [2:0]              j_run_q, j_run_d;
  logic [LENGTH_WIDTH-1:0] byte_cnt_q, byte_cnt_d;
  logic                    capture_q, capture_d;
  logic                    ready_q, ready_d;
  logic [LENGTH_WIDTH-1:0] length_q, length_d;
  logic                    error_q, error_d;
  logic                    dropped_q, dropped_d;
  logic [7:0]              read_data_q;
  logic                    line_j, line_k, line_se0, line_se1;
  logic                    sample, rx_bit, fail;
  logic [7:0]              rx_byte;
  logic                    wr_en;
  logic [7:0]              mem [BUFFER_BYTES];

  assign line_j   =  dp_sync_q && !dn_sync_q;
  assign line_k   = !dp_sync_q &&  dn_sync_q;
  assign line_se0 = !dp_sync_q && !dn_sync_q;
  assign line_se1 =  dp_sync_q &&  dn_sync_q;

  // Bit phase realigns on every D+ edge; the line is sampled mid-bit.
  assign phase_now = (dp_sync_q != dp_prev_q) ? '0 : phase_q;
  assign phase_d   = (phase_now == PHASE_LAST) ? '0 : phase_now + PHASE_W'(1);
  assign sample    = (phase_now == PHASE_SAMPLE);
  assign rx_bit    = (dp_sync_q == prev_lvl_q);
  assign rx_byte   = {rx_bit, shift_q};

  assign se0_cnt_d = !line_se0 ? '0 :
                     (se0_cnt_q == RST_LIMIT) ? se0_cnt_q : se0_cnt_q + RST_W'(1);

  assign bus_reset      = (se0_cnt_q == RST_LIMIT);
  assign packet_ready   = ready_q;
  assign packet_length  = length_q;
  assign packet_error   = error_q;
  assign packet_dropped = dropped_q;
  assign read_data      = read_data_q;

  always_comb begin
    state_d    = state_q;
    prev_lvl_d = sample ? dp_sync_q : prev_lvl_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    ones_d     = ones_q;
    j_run_d    = j_run_q;
    byte_cnt_d = byte_cnt_q;
    capture_d  = capture_q;
    ready_d    = ready_q;
    length_d   = length_q;
    error_d    = 1'b0;
    dropped_d  = 1'b0;
    wr_en      = 1'b0;
    fail       = 1'b0;

    if (packet_ack && ready_q) ready_d = 1'b0;

    if (bus_reset) begin
      state_d = IDLE;
      ready_d = 1'b0;
    end else if (sample) begin
      case (state_q)
        IDLE: begin
          if (line_k) begin
            // The first K is already the first sync bit (a decoded 0).
            state_d    = SYNC;
            shift_d    = '0;
            bit_cnt_d  = 3'd1;
            ones_d     = '0;
            byte_cnt_d = '0;
            capture_d  = !ready_d;
          end
        end
        SYNC: begin
          if (line_se0 || line_se1) begin
            fail = 1'b1;
          end else begin
            shift_d   = rx_byte[7:1];
            ones_d    = rx_bit ? ones_q + 3'd1 : 3'd0;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (rx_byte == 8'h80) state_d = DATA;
              else fail = 1'b1;
            end
          end
        end
        DATA: begin
          if (line_se0) begin
            state_d = EOP;
          end else if (line_se1) begin
            fail = 1'b1;
          end else if (ones_q == 3'd6) begin
            if (rx_bit) fail = 1'b1;
            else ones_d = 3'd0;
          end else begin
            ones_d    = rx_bit ? ones_q + 3'd1 : 3'd0;
            shift_d   = rx_byte[7:1];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (byte_cnt_q == BUF_FULL) begin
                fail = 1'b1;
              end else begin
                wr_en      = capture_q;
                byte_cnt_d = byte_cnt_q + LENGTH_WIDTH'(1);
              end
            end
          end
        end
        EOP: begin
          if (line_j) begin
            if (bit_cnt_q == 3'd0 && byte_cnt_q != '0) begin
              state_d = IDLE;
              if (capture_q) begin
                ready_d  = 1'b1;
                length_d = byte_cnt_q;
              end else begin
                dropped_d = 1'b1;
              end
            end else begin
              fail = 1'b1;
            end
          end else if (!line_se0) begin
            fail = 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (!line_j) j_run_d = '0;
          else if (j_run_q == 3'd7) state_d = IDLE;
          else j_run_d = j_run_q + 3'd1;
        end
        default: state_d = IDLE;
      endcase
      if (fail) begin
        error_d = 1'b1;
        state_d = WAIT_IDLE;
        j_run_d = '0;
      end
    end
  end

  always_ff @(posedge clock48) begin
    if (reset) begin
      dp_meta_q   <= 1'b1;
      dp_sync_q   <= 1'b1;
      dp_prev_q   <= 1'b1;
      dn_meta_q   <= 1'b0;
      dn_sync_q   <= 1'b0;
      phase_q     <= '0;
      se0_cnt_q   <= '0;
      state_q     <= IDLE;
      prev_lvl_q  <= 1'b1;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      ones_q      <= '0;
      j_run_q     <= '0;
      byte_cnt_q  <= '0;
      capture_q   <= 1'b0;
      ready_q     <= 1'b0;
      length_q    <= '0;
      error_q     <= 1'b0;
      dropped_q   <= 1'b0;
      read_data_q <= '0;
    end else begin
      dp_meta_q   <= data;
      dp_sync_q   <= dp_meta_q;
      dp_prev_q   <= dp_sync_q;
      dn_meta_q   <= data_n;
      dn_sync_q   <= dn_meta_q;
      phase_q     <= phase_d;
      se0_cnt_q   <= se0_cnt_d;
      state_q     <= state_d;
      prev_lvl_q  <= prev_lvl_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      ones_q      <= ones_d;
      j_run_q     <= j_run_d;
      byte_cnt_q  <= byte_cnt_d;
      capture_q   <= capture_d;
      ready_q     <= ready_d;
      length_q    <= length_d;
      error_q     <= error_d;
      dropped_q   <= dropped_d;
      read_data_q <= mem[read_address];
    end
  end

  // Packet RAM is deliberately left unreset.
  always_ff @(posedge clock48) begin
    if (wr_en) mem[byte_cnt_q[ADDR_WIDTH-1:0]] <= rx_byte;
  end

endmodule

// File: tb/tb_usb_fs_receiver.sv
// Drives two receivers (64-byte and 4-byte buffers) from one line and checks them against a packet-level model.
module tb_usb_fs_receiver;
  localparam int OV = 4;
  localparam logic [1:0] LJ = 2'b10, LK = 2'b01, LSE0 = 2'b00;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, dp, dn, ack;
  logic [5:0] raddr;
  logic       br0, rdy0, err0, drp0, br1, rdy1, err1, drp1;
  logic [6:0] len0;
  logic [2:0] len1;
  logic [7:0] rd0, rd1;

  usb_fs_receiver #(.OVERSAMPLE(OV), .BUFFER_BYTES(64), .RESET_DETECT_CYCLES(120)) dut0 (
    .clock48(clk), .reset(rst), .data(dp), .data_n(dn), .bus_reset(br0),
    .packet_ready(rdy0), .packet_length(len0), .packet_error(err0), .packet_dropped(drp0),
    .packet_ack(ack), .read_address(raddr), .read_data(rd0));

  usb_fs_receiver #(.OVERSAMPLE(OV), .BUFFER_BYTES(4), .RESET_DETECT_CYCLES(120)) dut1 (
    .clock48(clk), .reset(rst), .data(dp), .data_n(dn), .bus_reset(br1),
    .packet_ready(rdy1), .packet_length(len1), .packet_error(err1), .packet_dropped(drp1),
    .packet_ack(ack), .read_address(raddr[1:0]), .read_data(rd1));

  int checks = 0, errors = 0;
  int depth [2] = '{64, 4};
  bit exp_rdy [2];
  int exp_len [2];
  logic [7:0] exp_mem [2][64];
  int exp_err [2], exp_drp [2], got_err [2], got_drp [2];
  bit exp_br, chk_en;
  bit dbits [$];
  bit tx_bits [$];

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (err0) got_err[0]++;
    if (err1) got_err[1]++;
    if (drp0) got_drp[0]++;
    if (drp1) got_drp[1]++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready0", rdy0, exp_rdy[0]);
      check("ready1", rdy1, exp_rdy[1]);
      check("bus_reset0", br0, exp_br);
      check("bus_reset1", br1, exp_br);
      if (exp_rdy[0]) check("length0", len0, exp_len[0]);
      if (exp_rdy[1]) check("length1", len1, exp_len[1]);
    end
  end

  task automatic add_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) dbits.push_back(b[i]);
  endtask

  // Outcome from the receive rules: unstuff, then classify by length, alignment and buffer depth.
  task automatic model_apply(input int d);
    logic [7:0] rx [$];
    logic [7:0] cur;
    int ones, nb;
    bit bad;
    ones = 1; nb = 0; bad = 0; cur = '0;
    foreach (tx_bits[i]) begin
      if (ones == 6) begin
        if (tx_bits[i]) bad = 1;
        ones = 0;
      end else begin
        ones = tx_bits[i] ? ones + 1 : 0;
        cur[nb % 8] = tx_bits[i];
        nb++;
        if (nb % 8 == 0) rx.push_back(cur);
      end
    end
    if (bad || nb % 8 != 0 || nb == 0 || rx.size() > depth[d]) exp_err[d]++;
    else if (exp_rdy[d]) exp_drp[d]++;
    else begin
      exp_rdy[d] = 1;
      exp_len[d] = rx.size();
      foreach (rx[i]) exp_mem[d][i] = rx[i];
    end
  endtask

  task automatic send_pkt(input bit stuff, input bit jit);
    logic [1:0] lv [$];
    bit lvl, b;
    int ones, dur;
    tx_bits.delete();
    ones = 1;
    foreach (dbits[i]) begin
      tx_bits.push_back(dbits[i]);
      ones = dbits[i] ? ones + 1 : 0;
      if (stuff && ones == 6) begin
        tx_bits.push_back(1'b0);
        ones = 0;
      end
    end
    lvl = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i != 7) lvl = ~lvl;
      lv.push_back(lvl ? LJ : LK);
    end
    foreach (tx_bits[i]) begin
      b = tx_bits[i];
      if (!b) lvl = ~lvl;
      lv.push_back(lvl ? LJ : LK);
    end
    lv.push_back(LSE0);
    lv.push_back(LSE0);
    lv.push_back(LJ);
    foreach (lv[i]) begin
      dur = OV;
      if (jit && (i == lv.size() - 1 || lv[i+1] != lv[i])) dur = OV + int'($urandom_range(2, 0)) - 1;
      {dp, dn} = lv[i];
      tick(dur);
    end
  endtask

  task automatic packet(input bit stuff, input bit jit, input string tag);
    chk_en = 0;
    send_pkt(stuff, jit);
    {dp, dn} = LJ;
    tick(12 * OV);
    model_apply(0);
    model_apply(1);
    for (int d = 0; d < 2; d++) begin
      check({tag, "_errors"}, got_err[d], exp_err[d]);
      check({tag, "_drops"}, got_drp[d], exp_drp[d]);
    end
    chk_en = 1;
    if (exp_rdy[0]) begin
      for (int a = 0; a < exp_len[0]; a++) begin
        raddr = 6'(a);
        tick(1);
        check({tag, "_rd0"}, rd0, exp_mem[0][a]);
        if (exp_rdy[1] && a < exp_len[1]) check({tag, "_rd1"}, rd1, exp_mem[1][a]);
      end
    end
    dbits.delete();
    tick(4);
  endtask

  task automatic do_ack();
    chk_en = 0;
    ack = 1;
    tick(1);
    ack = 0;
    check("ack_ready0", rdy0, 0);
    check("ack_ready1", rdy1, 0);
    exp_rdy[0] = 0;
    exp_rdy[1] = 0;
    chk_en = 1;
    tick(4);
  endtask

  initial begin
    rst = 1; dp = 1; dn = 0; ack = 0; raddr = '0; chk_en = 0; exp_br = 0;
    tick(3);
    check("rst_bus_reset", br0, 0);
    check("rst_ready", rdy0, 0);
    check("rst_length", len0, 0);
    check("rst_error", err0, 0);
    check("rst_dropped", drp0, 0);
    check("rst_read_data", rd0, 0);
    rst = 0;
    tick(1);
    chk_en = 1;
    tick(10);

    // Bus reset: high from the 122nd edge of SE0, low on the 3rd edge after J.
    chk_en = 0;
    {dp, dn} = LSE0;
    for (int k = 1; k <= 150; k++) begin
      tick(1);
      check("bus_reset_rise0", br0, int'(k >= 122));
      check("bus_reset_rise1", br1, int'(k >= 122));
    end
    {dp, dn} = LJ;
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      check("bus_reset_fall", br0, int'(k < 3));
    end
    chk_en = 1;
    tick(480);

    add_byte(8'hC3); add_byte(8'h01); add_byte(8'hAA);
    packet(1, 0, "pktA");
    check("pktA_len_lit", len0, 3);
    raddr = 6'd2; tick(1);
    check("pktA_byte2_lit", rd0, 8'hAA);
    check("pktA_no_error_lit", got_err[0], 0);
    do_ack();

    add_byte(8'hFF); add_byte(8'hFF);
    packet(1, 1, "pktB_jitter");
    check("pktB_len_lit", len0, 2);
    check("pktB_no_error_lit", got_err[0], 0);
    do_ack();

    add_byte(8'hFF);
    packet(0, 0, "pktC_stufferr");
    check("pktC_error_lit", got_err[0], 1);
    check("pktC_not_ready_lit", rdy0, 0);

    add_byte(8'h5A);
    packet(1, 0, "pktD");
    check("pktD_len_lit", len0, 1);
    raddr = 6'd0; tick(1);
    check("pktD_byte_lit", rd0, 8'h5A);

    add_byte(8'h11); add_byte(8'h22);
    packet(1, 0, "pktE_held");
    check("pktE_dropped_lit", got_drp[0], 1);
    check("pktE_len_kept_lit", len0, 1);
    do_ack();

    add_byte(8'h33); add_byte(8'h44); add_byte(8'h55);
    packet(1, 0, "pktF");
    check("pktF_len_lit", len0, 3);
    do_ack();

    for (int i = 1; i <= 5; i++) add_byte(8'(i));
    packet(1, 0, "pktG_overflow");
    check("pktG_len0_lit", len0, 5);
    check("pktG_ready1_lit", rdy1, 0);
    check("pktG_error1_lit", got_err[1], 2);
    do_ack();

    add_byte(8'h5A);
    dbits.push_back(1'b1); dbits.push_back(1'b0); dbits.push_back(1'b1); dbits.push_back(1'b0);
    packet(1, 0, "pktH_misaligned");
    check("pktH_error_lit", got_err[0], 2);

    packet(1, 0, "pktI_empty");

    add_byte(8'h77);
    packet(1, 1, "pktK");
    chk_en = 0;
    {dp, dn} = LSE0;
    tick(150);
    check("busrst_clears_ready0", rdy0, 0);
    check("busrst_clears_ready1", rdy1, 0);
    exp_rdy[0] = 0;
    exp_rdy[1] = 0;
    {dp, dn} = LJ;
    tick(10);
    chk_en = 1;
    tick(20);
    chk_en = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
